// File: rtl/mic_pkg.sv
// Shared constants and the capture state encoding for the I2S microphone front end.
package mic_pkg;

    localparam int DATA_WIDTH = 18;
    localparam int ADDR_WIDTH = 6;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] WS_FIRST = BIT_CNT_W'(SLOT_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] WS_LAST  = BIT_CNT_W'(FRAME_BITS - 2);

    // WS leads each slot by one SCK, so the right slot's WS spans the last bit of the
    // left slot through the second-to-last bit of the frame.
    function automatic logic ws_for_bit(input logic [BIT_CNT_W-1:0] b);
        return (b >= WS_FIRST) && (b <= WS_LAST);
    endfunction

endpackage

// File: rtl/mic_sck_gen.sv
// SCK divider: toggles mic_sck every CLK_DIV clk while run=1, holds it low otherwise.
// sck_rise/sck_fall are single-clk enables coincident with the mic_sck register update.
module mic_sck_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic mic_sck,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sck_q, sck_d;
    logic             term;

    always_comb begin
        term      = run && (div_cnt_q == DIV_LAST);
        sck_rise  = term && !sck_q;
        sck_fall  = term && sck_q;
        div_cnt_d = (!run || term) ? '0 : div_cnt_q + DIV_ONE;
        sck_d     = run ? (term ? ~sck_q : sck_q) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

    assign mic_sck = sck_q;

endmodule

// File: rtl/mic_i2s_capture.sv
// I2S mic master: generates SCK/WS, captures the left-slot sample, writes one sample per frame.
// Write lands one clk after the rise capturing the last data bit; no backpressure (circular FIFO).
module mic_i2s_capture #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 18,
    parameter int CLK_DIV    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  mic_sd,
    output logic                  mic_sck,
    output logic                  mic_ws,
    output logic                  fifo_we,
    output logic [ADDR_WIDTH-1:0] fifo_wr_addr,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  frame_done
);

    import mic_pkg::*;

    localparam logic [BIT_CNT_W-1:0]  CAP_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [0:0]            state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  ws_q, ws_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  wr_pend_q, wr_pend_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  frame_done_q, frame_done_d;

    logic sck_rise;
    logic sck_fall;
    logic capture;

    mic_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state_q == RUN),
        .mic_sck  (mic_sck),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    // Enable is only honoured at frame boundaries so a started frame always produces its write.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sck_fall) begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if ((bit_cnt_q == BIT_LAST) && !enable) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
        ws_d = (state_d == RUN) && ws_for_bit(bit_cnt_d);
    end

    always_comb begin
        capture      = sck_rise && (bit_cnt_q <= CAP_LAST);
        shift_d      = capture ? {shift_q[DATA_WIDTH-2:0], mic_sd} : shift_q;
        wr_pend_d    = sck_rise && (bit_cnt_q == CAP_LAST);
        we_d         = wr_pend_q;
        wr_data_d    = wr_pend_q ? shift_q : wr_data_q;
        frame_done_d = wr_pend_q && (wr_addr_q == '1);
        // Address advances the clk after the strobe so it is stable for the whole write.
        wr_addr_d    = we_q ? wr_addr_q + ADDR_ONE : wr_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            ws_q         <= 1'b0;
            shift_q      <= '0;
            wr_pend_q    <= 1'b0;
            we_q         <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ws_q         <= ws_d;
            shift_q      <= shift_d;
            wr_pend_q    <= wr_pend_d;
            we_q         <= we_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mic_ws       = ws_q;
    assign fifo_we      = we_q;
    assign fifo_wr_addr = wr_addr_q;
    assign fifo_wr_data = wr_data_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_mic_i2s_capture.sv
// Bench for mic_i2s_capture: an I2S mic model feeds per-frame samples; writes are logged and
// compared against a table of expected {addr, data, frame_done} plus enable/reset corner sequences.
module tb_mic_i2s_capture;

    localparam int AW   = 6;
    localparam int DW   = 18;
    localparam int CD   = 2;
    localparam int NTAB = 66;
    localparam int FRAME_CLK = 128 * CD;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic          mic_sd = 1'b0;
    logic          mic_sck;
    logic          mic_ws;
    logic          fifo_we;
    logic [AW-1:0] fifo_wr_addr;
    logic [DW-1:0] fifo_wr_data;
    logic          frame_done;

    always #5 clk = ~clk;

    mic_i2s_capture #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mic_sd       (mic_sd),
        .mic_sck      (mic_sck),
        .mic_ws       (mic_ws),
        .fifo_we      (fifo_we),
        .fifo_wr_addr (fifo_wr_addr),
        .fifo_wr_data (fifo_wr_data),
        .frame_done   (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- microphone model ----------------
    logic [DW-1:0] mic_left  [256];
    logic [DW-1:0] mic_right [256];
    int pos       = 0;
    int frame_idx = 0;

    function automatic logic mic_bit(input int p, input int f);
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        l = mic_left[f % 256];
        r = mic_right[f % 256];
        if (p < DW) return l[DW-1-p];
        if (p >= 32 && p < 32 + DW) return r[DW-1-(p-32)];
        return 1'b0;
    endfunction

    // A mic shifts its next bit out on every SCK falling edge; 64 SCKs per frame.
    always @(negedge mic_sck) begin
        if (rst_n) begin
            pos = (pos + 1) % 64;
            if (pos == 0) frame_idx = frame_idx + 1;
            mic_sd = mic_bit(pos, frame_idx);
        end
    end

    // ---------------- output monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int   n_wr = 0;
    int   wr_addr [256];
    int   wr_data [256];
    int   wr_fd   [256];
    int   wr_cyc  [256];
    int   stray_fd      = 0;
    int   last_rise_cyc = -1;
    int   sck_period    = 0;
    int   ws_hi_cnt     = 0;
    int   last_ws_hi    = 0;
    int   ws_rise_pos   = -1;
    logic prev_sck = 1'b0;
    logic prev_ws  = 1'b0;

    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            if (n_wr < 256) begin
                wr_addr[n_wr] = int'(fifo_wr_addr);
                wr_data[n_wr] = int'(fifo_wr_data);
                wr_fd[n_wr]   = int'(frame_done);
                wr_cyc[n_wr]  = cyc;
            end
            n_wr++;
        end
        if (frame_done === 1'b1 && fifo_we !== 1'b1) stray_fd++;
        if (mic_sck === 1'b1 && prev_sck === 1'b0) begin
            if (last_rise_cyc >= 0) sck_period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            if (mic_ws === 1'b1) ws_hi_cnt++;
        end
        if (mic_ws === 1'b1 && prev_ws === 1'b0) begin
            ws_rise_pos = pos;
            ws_hi_cnt   = 0;
        end
        if (mic_ws === 1'b0 && prev_ws === 1'b1) last_ws_hi = ws_hi_cnt;
        prev_sck = mic_sck;
        prev_ws  = mic_ws;
    end

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (n_wr < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_wr < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, got %0d writes, required %0d", name, n_wr, n);
        end
    endtask

    task automatic wait_pos(input int target, input int budget, input string name);
        int k = 0;
        while (pos != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (pos != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, bit position %0d, required %0d", name, pos, target);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_fd;
    } vec_t;

    vec_t          tab [NTAB];
    logic [DW-1:0] fixed_l [8];

    initial begin
        int bad;
        int base;
        int kf;
        int held;
        int fnew;

        fixed_l = '{18'h2A5A5, 18'h2A5A5, 18'h20001, 18'h1FFFE,
                    18'h3FFFF, 18'h00000, 18'h20000, 18'h1FFFF};
        for (int i = 0; i < NTAB; i++) begin
            tab[i].left     = (i < 8) ? fixed_l[i] : DW'($urandom);
            tab[i].right    = (i < 2) ? 18'h3FFFF : DW'($urandom);
            tab[i].exp_addr = AW'(i % 64);
            tab[i].exp_data = tab[i].left;
            tab[i].exp_fd   = ((i % 64) == 63);
        end
        for (int i = 0; i < 256; i++) begin
            mic_left[i]  = (i < NTAB) ? tab[i].left  : DW'($urandom);
            mic_right[i] = (i < NTAB) ? tab[i].right : DW'($urandom);
        end

        // Reset held with enable requested: everything stays quiet.
        rst_n  = 1'b0;
        enable = 1'b1;
        bad    = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mic_sck !== 1'b0 || mic_ws !== 1'b0 || fifo_we !== 1'b0 ||
                fifo_wr_addr !== '0 || fifo_wr_data !== '0 || frame_done !== 1'b0) bad++;
        end
        check("reset_quiet_cycles", bad, 0);
        check("reset_sck", mic_sck, 0);
        check("reset_ws", mic_ws, 0);
        check("reset_we", fifo_we, 0);
        check("reset_addr", fifo_wr_addr, 0);
        check("reset_fd", frame_done, 0);
        check("reset_writes", n_wr, 0);

        // Continuous run of NTAB frames: addresses wrap once, frame_done only at address 63.
        pos       = 0;
        frame_idx = 0;
        mic_sd    = mic_bit(0, 0);
        rst_n     = 1'b1;
        wait_writes(NTAB, NTAB * FRAME_CLK + 600, "run_writes");
        for (int i = 0; i < NTAB; i++) begin
            check($sformatf("w%0d_addr", i), wr_addr[i], tab[i].exp_addr);
            check($sformatf("w%0d_data", i), wr_data[i], tab[i].exp_data);
            check($sformatf("w%0d_fd", i), wr_fd[i], tab[i].exp_fd);
            if (i > 0) check($sformatf("w%0d_interval", i), wr_cyc[i] - wr_cyc[i-1], FRAME_CLK);
        end
        check("sck_period", sck_period, 2 * CD);
        check("ws_high_scks", last_ws_hi, 32);
        check("ws_rise_bit", ws_rise_pos, 31);

        // Drop enable mid-frame: that frame is still written, then SCK parks low.
        wait_pos(10, 8 * FRAME_CLK, "pos10");
        enable = 1'b0;
        kf     = frame_idx;
        base   = n_wr;
        wait_writes(base + 1, 2 * FRAME_CLK, "drop_write");
        check("drop_addr", wr_addr[base % 256], (base % 64));
        check("drop_data", wr_data[base % 256], int'(mic_left[kf % 256]));
        repeat (FRAME_CLK + 40) @(negedge clk);
        held = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mic_sck !== 1'b0 || fifo_wr_addr !== AW'((base + 1) % 64)) held++;
        end
        check("idle_hold", held, 0);
        check("idle_no_write", n_wr, base + 1);

        enable = 1'b1;
        wait_writes(base + 2, 2 * FRAME_CLK, "reen_write");
        check("reen_addr", wr_addr[(base + 1) % 256], ((base + 1) % 64));
        check("reen_data", wr_data[(base + 1) % 256], int'(mic_left[(kf + 1) % 256]));

        // Asynchronous reset in the middle of a sample.
        wait_pos(9, 2 * FRAME_CLK, "pos9");
        #2;
        base  = n_wr;
        rst_n = 1'b0;
        #1;
        check("arst_sck", mic_sck, 0);
        check("arst_ws", mic_ws, 0);
        check("arst_we", fifo_we, 0);
        check("arst_addr", fifo_wr_addr, 0);
        check("arst_data", fifo_wr_data, 0);
        check("arst_fd", frame_done, 0);
        fnew      = frame_idx + 1;
        frame_idx = fnew;
        pos       = 0;
        mic_sd    = mic_bit(0, fnew);
        repeat (20) @(negedge clk);
        check("arst_no_partial_write", n_wr, base);
        rst_n = 1'b1;
        wait_writes(base + 1, 2 * FRAME_CLK, "post_rst_write");
        check("post_rst_addr", wr_addr[base % 256], 0);
        check("post_rst_data", wr_data[base % 256], int'(mic_left[fnew % 256]));
        check("stray_frame_done", stray_fd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
